ysyx_24110015_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24110015_mem_arbiter
// PURPOSE
//  Shares the single instruction/data memory port between IFU fetches and LSU loads/stores.
//  Sits between ysyx_24110015_IFU / LSU and the memory-side controller that wraps pmem_read/pmem_write.
//  Arbitrates with valid/ready handshakes, registers the winning request and routes the response back.
//  Allows one transaction in flight at a time.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width; wmask is DATA_W/8 bits
//  LSU_PRIO  1   1: LSU always wins a tie; 0: round-robin on a tie
// PORTS
//  clk             in   1         clock, rising edge
//  rst             in   1         reset, asynchronous, active-low
//  ifu_req_valid   in   1         IFU fetch request
//  ifu_req_ready   out  1         IFU request accepted this cycle
//  ifu_req_addr    in   ADDR_W    fetch address (pc)
//  ifu_resp_valid  out  1         fetch data valid
//  ifu_resp_ready  in   1         IFU can take data
//  ifu_resp_rdata  out  DATA_W    instruction word
//  lsu_req_valid   in   1         LSU request
//  lsu_req_ready   out  1         LSU request accepted this cycle
//  lsu_req_addr    in   ADDR_W    load/store address
//  lsu_req_wen     in   1         1 = store
//  lsu_req_wdata   in   DATA_W    store data
//  lsu_req_wmask   in   DATA_W/8  byte-enable mask
//  lsu_resp_valid  out  1         load data valid, or store ack
//  lsu_resp_ready  in   1         LSU can take response
//  lsu_resp_rdata  out  DATA_W    load data (don't-care for stores)
//  mem_req_valid   out  1         request to memory
//  mem_req_ready   in   1         memory accepts request
//  mem_req_addr    out  ADDR_W    registered address
//  mem_req_wen     out  1         registered write enable
//  mem_req_wdata   out  DATA_W    registered write data
//  mem_req_wmask   out  DATA_W/8  registered mask
//  mem_resp_valid  in   1         memory response valid
//  mem_resp_ready  out  1         arbiter takes response
//  mem_resp_rdata  in   DATA_W    memory read data
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, owner=IFU, last=IFU. All valid/ready outputs and mem_req_* are 0.
//    Any in-flight transaction is dropped; the memory side must be reset on the same rst.
//  - FSM IDLE->REQ: entered when ifu_req_valid|lsu_req_valid.
//    * The x_req_ready of the winner is 1 combinationally, in IDLE only.
//    * Request fields are latched into mem_req_* on that edge.
//    * Tie: with LSU_PRIO=1 the LSU wins. With LSU_PRIO=0 the requester not equal to last wins.
//  - FSM REQ: mem_req_valid=1, fields held stable. Moves to RESP on mem_req_valid&mem_req_ready.
//  - FSM RESP: owner resp_valid=mem_resp_valid, resp_rdata=mem_resp_rdata, mem_resp_ready=owner resp_ready.
//    * The non-owner resp_valid is 0.
//    * On the response handshake: last<=owner, state->IDLE.
//  - Latency: accepted at edge N, mem_req_valid at N+1 at the earliest. The response is combinational to the master.
//    Minimum 3 cycles from request to the next accept.
//  - IFU requests drive wen=0, wmask=0.
//  - mem_req_ready is ignored outside REQ. mem_resp_ready=0 outside RESP, so an early response is held off.
//  - Masters may drop valid while not accepted. Fields are sampled only at acceptance.
// STRUCTURE
//  - ysyx_24110015_defines.vh holds:
//    * state localparams: IDLE=2'd0, REQ=2'd1, RESP=2'd2;
//    * owner encoding: IFU=1'b0, LSU=1'b1;
//    * ADDR_W/DATA_W defaults.
//  - Sub-module ysyx_24110015_arb2: combinational 2-way picker (req[1:0], last, prio_mode -> grant).
// TESTING
//  - Single IFU fetch, addr 0x80000000, mem ready at once, resp 0x00000413 two cycles later
//    -> ifu_resp_rdata=0x00000413, lsu_resp_valid stays 0.
//  - IFU and LSU valid in the same cycle, LSU_PRIO=1 -> LSU is served first, then IFU. No request is lost.
//  - LSU_PRIO=0, both valid for 4 transactions -> grants alternate LSU, IFU, LSU, IFU (last=IFU after reset).
//  - LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low for 5 cycles
//    -> mem_req_* stays stable throughout, and lsu_resp_valid appears after the memory response.
//  - Owner resp_ready held low 3 cycles while mem_resp_valid=1 -> mem_resp_ready=0 for those cycles,
//    and no new request is accepted.
//  - rst asserted during RESP -> all outputs are 0 the same cycle. After release, a fresh IFU fetch completes normally.

Source files
------------

// File: rtl/ysyx_24110015_mem_arbiter_pkg.sv
// Shared types and encodings for the IFU/LSU memory-port arbiter.
package ysyx_24110015_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Convert a one-hot grant (bit 0 = IFU, bit 1 = LSU) into an owner code.
    function automatic logic grant_owner(input logic [1:0] grant);
        return grant[1] ? OWNER_LSU : OWNER_IFU;
    endfunction

endpackage

// File: rtl/ysyx_24110015_mem_arbiter_arb2.sv
// Two-way combinational picker: fixed LSU priority or alternate-on-tie.
module ysyx_24110015_arb2
    import ysyx_24110015_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic [1:0] grant
);

    // Choose one requester; bit 0 = IFU, bit 1 = LSU
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (prio_mode) begin
                    grant = 2'b10;
                end else if (last == OWNER_LSU) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores,
// one transaction in flight, request fields registered at acceptance.
module ysyx_24110015_mem_arbiter
    import ysyx_24110015_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit LSU_PRIO = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e        state_r;
    arb_state_e        state_next_s;
    logic              owner_r;
    logic              last_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wen_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MASK_W-1:0] wmask_r;
    logic [1:0]        grant_s;
    logic              accept_s;
    logic              resp_hs_s;
    logic              owner_resp_ready_s;

    ysyx_24110015_arb2 u_arb2 (
        .req       ({lsu_req_valid, ifu_req_valid}),
        .last      (last_r),
        .prio_mode (LSU_PRIO),
        .grant     (grant_s)
    );

    // Next-state decode plus accept / response-handshake qualifiers
    always_comb begin
        state_next_s       = state_r;
        accept_s           = 1'b0;
        resp_hs_s          = 1'b0;
        owner_resp_ready_s = (owner_r == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid && owner_resp_ready_s) begin
                    resp_hs_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Master-facing handshakes; forced low while reset is asserted
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = {DATA_W{1'b0}};
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = {DATA_W{1'b0}};
        mem_resp_ready = 1'b0;
        if (rst && (state_r == ST_IDLE)) begin
            ifu_req_ready = grant_s[0];
            lsu_req_ready = grant_s[1];
        end else if (rst && (state_r == ST_RESP)) begin
            mem_resp_ready = owner_resp_ready_s;
            if (owner_r == OWNER_LSU) begin
                lsu_resp_valid = mem_resp_valid;
                lsu_resp_rdata = mem_resp_rdata;
            end else begin
                ifu_resp_valid = mem_resp_valid;
                ifu_resp_rdata = mem_resp_rdata;
            end
        end else begin
            mem_resp_ready = 1'b0;
        end
    end

    // State, ownership history and latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            owner_r <= OWNER_IFU;
            last_r  <= OWNER_IFU;
            addr_r  <= {ADDR_W{1'b0}};
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                owner_r <= grant_owner(grant_s);
                if (grant_s[1]) begin
                    addr_r  <= lsu_req_addr;
                    wen_r   <= lsu_req_wen;
                    wdata_r <= lsu_req_wdata;
                    wmask_r <= lsu_req_wmask;
                end else begin
                    addr_r  <= ifu_req_addr;
                    wen_r   <= 1'b0;
                    wdata_r <= {DATA_W{1'b0}};
                    wmask_r <= {MASK_W{1'b0}};
                end
            end
            if (resp_hs_s) begin
                last_r <= owner_r;
            end
        end
    end

    assign mem_req_valid = (state_r == ST_REQ);
    assign mem_req_addr  = addr_r;
    assign mem_req_wen   = wen_r;
    assign mem_req_wdata = wdata_r;
    assign mem_req_wmask = wmask_r;

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (fixed-priority and round-robin builds).
module tb_ysyx_24110015_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_req_addr = 32'h0;
    logic        ifu_resp_valid, ifu_resp_ready = 1'b0;
    logic [31:0] ifu_resp_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_req_addr = 32'h0;
    logic        lsu_req_wen = 1'b0;
    logic [31:0] lsu_req_wdata = 32'h0;
    logic [3:0]  lsu_req_wmask = 4'h0;
    logic        lsu_resp_valid, lsu_resp_ready = 1'b0;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0, mem_resp_ready;
    logic [31:0] mem_resp_rdata = 32'h0;

    logic        rr_ifu_valid = 1'b0, rr_ifu_ready;
    logic        rr_lsu_valid = 1'b0, rr_lsu_ready;
    logic        rr_ifu_resp_valid, rr_lsu_resp_valid;
    logic [31:0] rr_ifu_rdata, rr_lsu_rdata;
    logic        rr_mem_req_valid, rr_mem_req_wen, rr_mem_resp_ready;
    logic [31:0] rr_mem_req_addr, rr_mem_req_wdata;
    logic [3:0]  rr_mem_req_wmask;
    logic        one = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
    );

    ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .ifu_req_valid(rr_ifu_valid), .ifu_req_ready(rr_ifu_ready), .ifu_req_addr(32'h8000_0000),
        .ifu_resp_valid(rr_ifu_resp_valid), .ifu_resp_ready(one), .ifu_resp_rdata(rr_ifu_rdata),
        .lsu_req_valid(rr_lsu_valid), .lsu_req_ready(rr_lsu_ready), .lsu_req_addr(32'h8000_0100),
        .lsu_req_wen(1'b0), .lsu_req_wdata(32'h0), .lsu_req_wmask(4'hF),
        .lsu_resp_valid(rr_lsu_resp_valid), .lsu_resp_ready(one), .lsu_resp_rdata(rr_lsu_rdata),
        .mem_req_valid(rr_mem_req_valid), .mem_req_ready(one), .mem_req_addr(rr_mem_req_addr),
        .mem_req_wen(rr_mem_req_wen), .mem_req_wdata(rr_mem_req_wdata), .mem_req_wmask(rr_mem_req_wmask),
        .mem_resp_valid(one), .mem_resp_ready(rr_mem_resp_ready), .mem_resp_rdata(32'h0000_0000)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full IFU fetch: accept, memory accepts at once, response two cycles after accept.
    task automatic run_ifu(input logic [31:0] addr, input logic [31:0] data);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = addr;
        #1;
        check("ifu_accept_ready", 96'(ifu_req_ready), 96'(1'b1));
        check("ifu_accept_lsu_ready", 96'(lsu_req_ready), 96'(1'b0));
        step();
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h0;
        mem_req_ready = 1'b1;
        #1;
        check("ifu_mem_valid", 96'(mem_req_valid), 96'(1'b1));
        check("ifu_mem_addr", 96'(mem_req_addr), 96'(addr));
        check("ifu_mem_wen", 96'(mem_req_wen), 96'(1'b0));
        check("ifu_mem_wmask", 96'(mem_req_wmask), 96'(4'h0));
        check("ifu_no_reaccept", 96'(ifu_req_ready), 96'(1'b0));
        step();
        mem_req_ready = 1'b0;
        #1;
        check("ifu_mem_valid_drop", 96'(mem_req_valid), 96'(1'b0));
        check("ifu_resp_wait", 96'(ifu_resp_valid), 96'(1'b0));
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = data;
        ifu_resp_ready = 1'b1;
        #1;
        check("ifu_resp_valid", 96'(ifu_resp_valid), 96'(1'b1));
        check("ifu_resp_rdata", 96'(ifu_resp_rdata), 96'(data));
        check("ifu_lsu_resp_quiet", 96'(lsu_resp_valid), 96'(1'b0));
        check("ifu_mem_resp_ready", 96'(mem_resp_ready), 96'(1'b1));
        step();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        #1;
        check("ifu_back_idle", 96'(ifu_resp_valid), 96'(1'b0));
    endtask

    initial begin
        logic [3:0] grants;
        int         n_gr;
        logic [31:0] st_addr;

        // Reset state with a request already pending
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        #12;
        check("rst_ifu_ready", 96'(ifu_req_ready), 96'(1'b0));
        check("rst_mem_valid", 96'(mem_req_valid), 96'(1'b0));
        check("rst_mem_addr", 96'(mem_req_addr), 96'(32'h0));
        check("rst_mem_resp_ready", 96'(mem_resp_ready), 96'(1'b0));
        check("rst_lsu_resp", 96'(lsu_resp_valid), 96'(1'b0));
        ifu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Round-robin build: both always valid, grants must alternate LSU, IFU, LSU, IFU
        rr_ifu_valid = 1'b1;
        rr_lsu_valid = 1'b1;
        grants = 4'b0000;
        n_gr   = 0;
        for (int c = 0; c < 30 && n_gr < 4; c++) begin
            #1;
            if (rr_ifu_ready || rr_lsu_ready) begin
                check("rr_single_grant", 96'(rr_ifu_ready & rr_lsu_ready), 96'(1'b0));
                grants[n_gr] = rr_lsu_ready;
                n_gr++;
            end
            step();
        end
        rr_ifu_valid = 1'b0;
        rr_lsu_valid = 1'b0;
        check("rr_grant_count", 96'(n_gr), 96'(4));
        check("rr_grant_order", 96'(grants), 96'(4'b0101));

        // Single IFU fetch
        run_ifu(32'h8000_0000, 32'h0000_0413);

        // Tie with LSU priority: LSU first, IFU keeps waiting and is served next
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_0100;
        lsu_req_wen   = 1'b0;
        lsu_req_wmask = 4'hF;
        #1;
        check("tie_lsu_ready", 96'(lsu_req_ready), 96'(1'b1));
        check("tie_ifu_ready", 96'(ifu_req_ready), 96'(1'b0));
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("tie_mem_addr_lsu", 96'(mem_req_addr), 96'(32'h8000_0100));
        check("tie_ifu_blocked", 96'(ifu_req_ready), 96'(1'b0));
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_2222;
        lsu_resp_ready = 1'b1;
        ifu_resp_ready = 1'b1;
        #1;
        check("tie_lsu_resp_valid", 96'(lsu_resp_valid), 96'(1'b1));
        check("tie_lsu_resp_rdata", 96'(lsu_resp_rdata), 96'(32'h1111_2222));
        check("tie_ifu_resp_quiet", 96'(ifu_resp_valid), 96'(1'b0));
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("tie_ifu_now_ready", 96'(ifu_req_ready), 96'(1'b1));
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("tie_mem_addr_ifu", 96'(mem_req_addr), 96'(32'h8000_0004));
        check("tie_mem_wen_ifu", 96'(mem_req_wen), 96'(1'b0));
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h3333_4444;
        #1;
        check("tie_ifu_resp_rdata", 96'(ifu_resp_rdata), 96'(32'h3333_4444));
        check("tie_lsu_resp_quiet", 96'(lsu_resp_valid), 96'(1'b0));
        step();
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b0;
        ifu_resp_ready = 1'b0;

        // Store with memory back-pressure: fields must hold while mem_req_ready is low
        st_addr       = 32'h8000_1000;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = st_addr;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'hF;
        #1;
        check("st_accept", 96'(lsu_req_ready), 96'(1'b1));
        step();
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'h0;
        lsu_req_wmask = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("st_hold_valid", 96'(mem_req_valid), 96'(1'b1));
            check("st_hold_addr", 96'(mem_req_addr), 96'(32'h8000_1000));
            check("st_hold_wdata", 96'(mem_req_wdata), 96'(32'hDEAD_BEEF));
            check("st_hold_wmask_wen", 96'({mem_req_wmask, mem_req_wen}), 96'(5'b1111_1));
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        check("st_still_valid", 96'(mem_req_valid), 96'(1'b1));
        step();
        mem_req_ready = 1'b0;
        #1;
        check("st_no_early_resp", 96'(lsu_resp_valid), 96'(1'b0));
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0;
        lsu_resp_ready = 1'b1;
        #1;
        check("st_ack", 96'(lsu_resp_valid), 96'(1'b1));
        step();
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b0;

        // Owner not ready for 3 cycles: response held off, pending LSU not accepted
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0008;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0055;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 32'h8000_2000;
        lsu_req_wen    = 1'b0;
        lsu_req_wmask  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_mem_resp_ready", 96'(mem_resp_ready), 96'(1'b0));
            check("bp_ifu_resp_valid", 96'(ifu_resp_valid), 96'(1'b1));
            check("bp_lsu_blocked", 96'(lsu_req_ready), 96'(1'b0));
            step();
        end
        ifu_resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 96'(mem_resp_ready), 96'(1'b1));
        check("bp_release_rdata", 96'(ifu_resp_rdata), 96'(32'h0000_0055));
        step();
        ifu_resp_ready = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        check("bp_lsu_accept", 96'(lsu_req_ready), 96'(1'b1));
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("bp_lsu_addr", 96'(mem_req_addr), 96'(32'h8000_2000));
        step();

        // Reset in RESP: outputs drop in the same cycle
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0066;
        lsu_resp_ready = 1'b1;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h8000_000C;
        #1;
        check("rr_pre_lsu_resp", 96'(lsu_resp_valid), 96'(1'b1));
        rst = 1'b0;
        #1;
        check("rr_lsu_resp_off", 96'(lsu_resp_valid), 96'(1'b0));
        check("rr_lsu_rdata_off", 96'(lsu_resp_rdata), 96'(32'h0));
        check("rr_mem_resp_ready_off", 96'(mem_resp_ready), 96'(1'b0));
        check("rr_ifu_ready_off", 96'(ifu_req_ready), 96'(1'b0));
        check("rr_mem_req_off", 96'({mem_req_valid, mem_req_addr}), 96'(33'h0));
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b0;
        ifu_req_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        run_ifu(32'h8000_0010, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
